// File: rtl/mgmt_wb_arb_pkg.sv
// Shared constants for the mgmt_wb_arbiter slice: FSM encoding, master indices,
// default forced-completion read data.
package mgmt_wb_arb_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GNT0  = 3'd1;
  localparam logic [2:0] ST_GNT1  = 3'd2;
  localparam logic [2:0] ST_TOUT0 = 3'd3;
  localparam logic [2:0] ST_TOUT1 = 3'd4;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;

  // One-hot grant owned by a state; a TOUT cycle still belongs to its master.
  function automatic logic [1:0] grant_of(input logic [2:0] st);
    case (st)
      ST_GNT0, ST_TOUT0: grant_of = 2'b01;
      ST_GNT1, ST_TOUT1: grant_of = 2'b10;
      default:           grant_of = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mgmt_wb_arbiter_if.sv
// Classic Wishbone bus bundle used for both master-side and slave-side ports
// of mgmt_wb_arbiter.
interface mgmt_wb_arbiter_if;
  // Handshake: a transfer is offered while cyc&stb are high (valid) and completes
  // on the cycle ack is high (ready); the initiator holds we/sel/adr/dat_w stable
  // until that cycle, and cyc may stay high across several transfers (lock).
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic        ack;
  logic [31:0] dat_r;

  modport master (output cyc, stb, we, sel, adr, dat_w, input ack, dat_r);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, output ack, dat_r);
endinterface

// File: rtl/mgmt_wb_arb_timer.sv
// Saturating watchdog counter: counts while en, clears on clr, and flags the
// cycle whose count step reaches LIMIT.
module mgmt_wb_arb_timer #(
  parameter int W     = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic hit
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  // hit fires during the LIMIT-th counted cycle so the FSM moves on the next edge.
  assign hit = en && (count == W'(LIMIT - 1));

endmodule

// File: rtl/mgmt_wb_arbiter.sv
// Two-master / one-slave round-robin Wishbone arbiter for the user-project bus.
// Optional hung-transfer watchdog enabled by MGMT_WB_ARB_TIMEOUT_EN.
module mgmt_wb_arbiter
  import mgmt_wb_arb_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          TIMEOUT_W      = 8,
  parameter logic [31:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEFAULT
) (
  input  logic                core_clk,
  input  logic                core_rstn,
  mgmt_wb_arbiter_if.slave    m0,
  mgmt_wb_arbiter_if.slave    m1,
  mgmt_wb_arbiter_if.master   s,
  output logic [1:0]          gnt_o,
  output logic                timeout_o,
  output logic [2:0]          state_o
);

  logic [2:0] state, state_nxt;
  logic       last_gnt, last_gnt_nxt;
  logic       wd_hit;

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      state    <= ST_IDLE;
      last_gnt <= M1;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  // Every grant returns through IDLE, so the tie-break always sees fresh requests.
  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    case (state)
      ST_IDLE: begin
        if (m0.cyc && m1.cyc) state_nxt = (last_gnt == M0) ? ST_GNT1 : ST_GNT0;
        else if (m0.cyc)      state_nxt = ST_GNT0;
        else if (m1.cyc)      state_nxt = ST_GNT1;
      end
      ST_GNT0: begin
        if (!m0.cyc) begin
          state_nxt    = ST_IDLE;
          last_gnt_nxt = M0;
        end else if (wd_hit) begin
          state_nxt = ST_TOUT0;
        end
      end
      ST_GNT1: begin
        if (!m1.cyc) begin
          state_nxt    = ST_IDLE;
          last_gnt_nxt = M1;
        end else if (wd_hit) begin
          state_nxt = ST_TOUT1;
        end
      end
      ST_TOUT0: begin
        if (!m0.cyc) begin
          state_nxt    = ST_IDLE;
          last_gnt_nxt = M0;
        end else begin
          state_nxt = ST_GNT0;
        end
      end
      ST_TOUT1: begin
        if (!m1.cyc) begin
          state_nxt    = ST_IDLE;
          last_gnt_nxt = M1;
        end else begin
          state_nxt = ST_GNT1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  logic        s_cyc_d, s_stb_d, s_we_d;
  logic [3:0]  s_sel_d;
  logic [31:0] s_adr_d, s_dat_d;
  logic        m0_ack_d, m1_ack_d;
  logic [31:0] m0_dat_d, m1_dat_d;

  // Zero-latency pass-through while granted; a TOUT cycle hides the slave entirely,
  // so a late s_ack_i in that cycle is dropped.
  always_comb begin
    s_cyc_d  = 1'b0;
    s_stb_d  = 1'b0;
    s_we_d   = 1'b0;
    s_sel_d  = '0;
    s_adr_d  = '0;
    s_dat_d  = '0;
    m0_ack_d = 1'b0;
    m1_ack_d = 1'b0;
    m0_dat_d = '0;
    m1_dat_d = '0;
    case (state)
      ST_GNT0: begin
        s_cyc_d  = m0.cyc;
        s_stb_d  = m0.stb;
        s_we_d   = m0.we;
        s_sel_d  = m0.sel;
        s_adr_d  = m0.adr;
        s_dat_d  = m0.dat_w;
        m0_ack_d = s.ack;
        m0_dat_d = s.dat_r;
      end
      ST_GNT1: begin
        s_cyc_d  = m1.cyc;
        s_stb_d  = m1.stb;
        s_we_d   = m1.we;
        s_sel_d  = m1.sel;
        s_adr_d  = m1.adr;
        s_dat_d  = m1.dat_w;
        m1_ack_d = s.ack;
        m1_dat_d = s.dat_r;
      end
      ST_TOUT0: begin
        m0_ack_d = 1'b1;
        m0_dat_d = TIMEOUT_DATA;
      end
      ST_TOUT1: begin
        m1_ack_d = 1'b1;
        m1_dat_d = TIMEOUT_DATA;
      end
      default: ;
    endcase
  end

  assign s.cyc   = s_cyc_d;
  assign s.stb   = s_stb_d;
  assign s.we    = s_we_d;
  assign s.sel   = s_sel_d;
  assign s.adr   = s_adr_d;
  assign s.dat_w = s_dat_d;
  assign m0.ack   = m0_ack_d;
  assign m0.dat_r = m0_dat_d;
  assign m1.ack   = m1_ack_d;
  assign m1.dat_r = m1_dat_d;

  assign gnt_o   = grant_of(state);
  assign state_o = state;

`ifdef MGMT_WB_ARB_TIMEOUT_EN
  logic wd_en;

  // Count only cycles where the granted master strobes and the slave stays silent.
  assign wd_en = (((state == ST_GNT0) && m0.stb) ||
                  ((state == ST_GNT1) && m1.stb)) && !s.ack;

  mgmt_wb_arb_timer #(
    .W     (TIMEOUT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (core_clk),
    .rst_n (core_rstn),
    .en    (wd_en),
    .clr   (!wd_en),
    .hit   (wd_hit)
  );

  assign timeout_o = (state == ST_TOUT0) || (state == ST_TOUT1);
`else
  assign wd_hit    = 1'b0;
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_mgmt_wb_arbiter.sv
// Directed bench for mgmt_wb_arbiter; timeout scenarios run when built with
// MGMT_WB_ARB_TIMEOUT_EN, otherwise the hung-slave stall is checked.
module tb_mgmt_wb_arbiter;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GNT0  = 3'd1;
  localparam logic [2:0] ST_GNT1  = 3'd2;
  localparam logic [2:0] ST_TOUT0 = 3'd3;

  logic        core_clk;
  logic        core_rstn;
  logic [1:0]  gnt_o;
  logic        timeout_o;
  logic [2:0]  state_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  mgmt_wb_arbiter_if m0_bus ();
  mgmt_wb_arbiter_if m1_bus ();
  mgmt_wb_arbiter_if s_bus ();

  mgmt_wb_arbiter #(
    .TIMEOUT_CYCLES (4),
    .TIMEOUT_W      (8),
    .TIMEOUT_DATA   (32'hDEAD_BEEF)
  ) dut (
    .core_clk  (core_clk),
    .core_rstn (core_rstn),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .s         (s_bus),
    .gnt_o     (gnt_o),
    .timeout_o (timeout_o),
    .state_o   (state_o)
  );

  // clock / reset
  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  initial begin
    #200000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expected);
    checks++;
    if (obs !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expected);
    end
  endtask

  // drivers: step to just after a rising edge, then settle after input changes
  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_m0(input logic cyc, input logic stb, input logic [31:0] adr);
    m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = 1'b0;
    m0_bus.sel = 4'hF; m0_bus.adr = adr; m0_bus.dat_w = 32'h0;
  endtask

  task automatic drive_m1(input logic cyc, input logic stb, input logic [31:0] adr);
    m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = 1'b0;
    m1_bus.sel = 4'hF; m1_bus.adr = adr; m1_bus.dat_w = 32'h0;
  endtask

  task automatic drive_slave(input logic ack, input logic [31:0] dat);
    s_bus.ack = ack; s_bus.dat_r = dat;
  endtask

  task automatic do_reset();
    core_rstn = 1'b0;
    repeat (2) tick();
    #2 core_rstn = 1'b1;
    tick();
  endtask

  initial begin
    drive_m0(1'b0, 1'b0, 32'h0);
    drive_m1(1'b0, 1'b0, 32'h0);
    drive_slave(1'b0, 32'h0);
    core_rstn = 1'b0;
    #1;
    check("rst_gnt_async", {30'b0, gnt_o}, 32'h0);
    do_reset();

    // reset with both masters idle
    check("rst_gnt",     {30'b0, gnt_o}, 32'h0);
    check("rst_s_cyc",   {31'b0, s_bus.cyc}, 32'h0);
    check("rst_s_adr",   s_bus.adr, 32'h0);
    check("rst_m0_ack",  {31'b0, m0_bus.ack}, 32'h0);
    check("rst_timeout", {31'b0, timeout_o}, 32'h0);
    check("rst_state",   {29'b0, state_o}, {29'b0, ST_IDLE});

    // single master M1 read
    drive_m1(1'b1, 1'b1, 32'h3000_0004);
    settle();
    check("m1_lat_gnt", {30'b0, gnt_o}, 32'h0);
    tick();
    check("m1_gnt",   {30'b0, gnt_o}, 32'h2);
    check("m1_s_adr", s_bus.adr, 32'h3000_0004);
    check("m1_s_stb", {31'b0, s_bus.stb}, 32'h1);
    drive_slave(1'b1, 32'h1234_5678);
    exp_q.push_back(32'h1234_5678);
    settle();
    check("m1_ack",    {31'b0, m1_bus.ack}, 32'h1);
    check("m1_dat",    m1_bus.dat_r, exp_q.pop_front());
    check("m1_m0_ack", {31'b0, m0_bus.ack}, 32'h0);
    check("m1_m0_dat", m0_bus.dat_r, 32'h0);
    tick();
    drive_slave(1'b0, 32'h0);
    drive_m1(1'b0, 1'b0, 32'h0);
    tick();
    check("m1_idle", {30'b0, gnt_o}, 32'h0);

    // simultaneous requests after reset: M0, then M1, then M0 again
    do_reset();
    drive_m0(1'b1, 1'b1, 32'h1000_0000);
    drive_m1(1'b1, 1'b1, 32'h2000_0000);
    tick();
    check("tie1_gnt",   {30'b0, gnt_o}, 32'h1);
    check("tie1_s_adr", s_bus.adr, 32'h1000_0000);
    drive_slave(1'b1, 32'hA5A5_0001);
    settle();
    check("tie1_m0_ack", {31'b0, m0_bus.ack}, 32'h1);
    check("tie1_m1_ack", {31'b0, m1_bus.ack}, 32'h0);
    tick();
    drive_slave(1'b0, 32'h0);
    drive_m0(1'b0, 1'b0, 32'h0);
    tick();
    check("tie1_idle", {29'b0, state_o}, {29'b0, ST_IDLE});
    tick();
    check("tie1_m1_gnt", {30'b0, gnt_o}, 32'h2);
    check("tie1_m1_adr", s_bus.adr, 32'h2000_0000);
    drive_m1(1'b0, 1'b0, 32'h0);
    tick();
    drive_m0(1'b1, 1'b1, 32'h1000_0010);
    drive_m1(1'b1, 1'b1, 32'h2000_0010);
    tick();
    check("tie2_gnt", {30'b0, gnt_o}, 32'h1);
    drive_m0(1'b0, 1'b0, 32'h0);
    tick();
    tick();
    check("tie2_m1_gnt", {30'b0, gnt_o}, 32'h2);
    drive_m1(1'b0, 1'b0, 32'h0);
    tick();

    // M0 locked burst of 4 acks with M1 requesting throughout
    drive_m0(1'b1, 1'b1, 32'h1000_0100);
    drive_m1(1'b1, 1'b1, 32'h2000_0100);
    tick();
    check("burst_gnt0", {30'b0, gnt_o}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      drive_slave(1'b1, 32'hB000_0000 + i);
      exp_q.push_back(32'hB000_0000 + i);
      settle();
      check("burst_ack", {31'b0, m0_bus.ack}, 32'h1);
      check("burst_dat", m0_bus.dat_r, exp_q.pop_front());
      check("burst_gnt", {30'b0, gnt_o}, 32'h1);
      tick();
      drive_slave(1'b0, 32'h0);
      settle();
      check("burst_gap_gnt", {30'b0, gnt_o}, 32'h1);
      tick();
    end
    drive_m0(1'b0, 1'b0, 32'h0);
    settle();
    check("burst_drop_gnt", {30'b0, gnt_o}, 32'h1);
    tick();
    check("burst_idle", {30'b0, gnt_o}, 32'h0);
    tick();
    check("burst_m1_gnt", {30'b0, gnt_o}, 32'h2);
    drive_m1(1'b0, 1'b0, 32'h0);
    tick();

`ifdef MGMT_WB_ARB_TIMEOUT_EN
    // slave never acks: 4 strobe cycles then one TOUT cycle
    drive_m0(1'b1, 1'b1, 32'h1000_0200);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("to_stb",     {31'b0, s_bus.stb}, 32'h1);
      check("to_no_ack",  {31'b0, m0_bus.ack}, 32'h0);
      check("to_no_tout", {31'b0, timeout_o}, 32'h0);
      tick();
    end
    check("to_state",  {29'b0, state_o}, {29'b0, ST_TOUT0});
    check("to_s_cyc",  {31'b0, s_bus.cyc}, 32'h0);
    check("to_s_stb",  {31'b0, s_bus.stb}, 32'h0);
    check("to_ack",    {31'b0, m0_bus.ack}, 32'h1);
    check("to_dat",    m0_bus.dat_r, 32'hDEAD_BEEF);
    check("to_pulse",  {31'b0, timeout_o}, 32'h1);
    drive_m0(1'b0, 1'b0, 32'h0);
    tick();
    check("to_pulse_end", {31'b0, timeout_o}, 32'h0);
    check("to_idle",      {29'b0, state_o}, {29'b0, ST_IDLE});

    // ack lands on the 4th strobe cycle: normal completion
    drive_m0(1'b1, 1'b1, 32'h1000_0300);
    tick();
    repeat (3) tick();
    drive_slave(1'b1, 32'h55AA_55AA);
    settle();
    check("ack4_ack", {31'b0, m0_bus.ack}, 32'h1);
    check("ack4_dat", m0_bus.dat_r, 32'h55AA_55AA);
    tick();
    drive_slave(1'b0, 32'h0);
    drive_m0(1'b0, 1'b0, 32'h0);
    settle();
    check("ack4_state", {29'b0, state_o}, {29'b0, ST_GNT0});
    check("ack4_no_to", {31'b0, timeout_o}, 32'h0);
    tick();
`else
    // no watchdog: a hung slave stalls the granted master
    drive_m0(1'b1, 1'b1, 32'h1000_0200);
    tick();
    repeat (10) tick();
    check("hang_gnt",     {30'b0, gnt_o}, 32'h1);
    check("hang_no_ack",  {31'b0, m0_bus.ack}, 32'h0);
    check("hang_no_tout", {31'b0, timeout_o}, 32'h0);
    check("hang_stb",     {31'b0, s_bus.stb}, 32'h1);
    drive_m0(1'b0, 1'b0, 32'h0);
    tick();
`endif
    check("pre_async_idle", {29'b0, state_o}, {29'b0, ST_IDLE});

    // async reset mid-transfer
    drive_m1(1'b1, 1'b1, 32'h3000_0008);
    tick();
    drive_slave(1'b1, 32'h0BAD_F00D);
    settle();
    check("ar_stb_pre", {31'b0, s_bus.stb}, 32'h1);
    check("ar_ack_pre", {31'b0, m1_bus.ack}, 32'h1);
    #1 core_rstn = 1'b0;
    #1;
    check("ar_stb",   {31'b0, s_bus.stb}, 32'h0);
    check("ar_cyc",   {31'b0, s_bus.cyc}, 32'h0);
    check("ar_adr",   s_bus.adr, 32'h0);
    check("ar_gnt",   {30'b0, gnt_o}, 32'h0);
    check("ar_m1ack", {31'b0, m1_bus.ack}, 32'h0);
    drive_slave(1'b0, 32'h0);
    drive_m1(1'b0, 1'b0, 32'h0);
    tick();
    #2 core_rstn = 1'b1;
    tick();
    check("ar_state", {29'b0, state_o}, {29'b0, ST_IDLE});
    check("ar_gnt_after", {30'b0, gnt_o}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
